// File: rtl/aw_w_steer_pkg.sv
// Shared definitions for the AW/W steering block: router state encodings,
// AW user-field width and the steering FSM state type.
package aw_w_steer_pkg;

    // Width of the AW user sideband carried from slave to master.
    localparam int PAWUSER_WIDTH = 4;

    // Router state as presented on routers_ps.
    typedef enum logic [2:0] {
        RP_REG_FLOW = 3'b000,
        RP_BLOCKED  = 3'b001,
        RP_MERGE    = 3'b010,
        RP_IDLE     = 3'b111
    } routers_ps_e;

    // Steering FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_DATA = 2'd2
    } steer_state_e;

    // Only the two routable states may open a new burst.
    function automatic logic accepts_aw(input logic [2:0] ps);
        return (ps == RP_REG_FLOW) || (ps == RP_MERGE);
    endfunction

endpackage

// File: rtl/aw_w_steer.sv
// AW/W steering block. Accepts one AXI write burst at a time and routes it
// either to the master AW/W channels (REG_FLOW) or to the proc memory write
// port (MERGE). The route is sampled once at AW acceptance and held for the
// whole burst.
// Optional feature: define STEER_LEN_CHECK_EN to add a beat counter and a
// sticky len_err flag; otherwise len_err is tied low and bursts terminate on
// s_wlast alone.
module aw_w_steer
    import aw_w_steer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2:0]               routers_ps,
    // Slave AW
    input  logic                     s_awvalid,
    output logic                     s_awready,
    input  logic [ADDR_W-1:0]        s_awaddr,
    input  logic [7:0]               s_awlen,
    input  logic [PAWUSER_WIDTH-1:0] s_awuser,
    // Slave W
    input  logic                     s_wvalid,
    output logic                     s_wready,
    input  logic [DATA_W-1:0]        s_wdata,
    input  logic                     s_wlast,
    // Master AW
    output logic                     m_awvalid,
    input  logic                     m_awready,
    output logic [ADDR_W-1:0]        m_awaddr,
    output logic [7:0]               m_awlen,
    output logic [PAWUSER_WIDTH-1:0] m_awuser,
    // Master W
    output logic                     m_wvalid,
    input  logic                     m_wready,
    output logic [DATA_W-1:0]        m_wdata,
    output logic                     m_wlast,
    // Proc memory write port
    input  logic                     proc_full,
    output logic                     proc_wr_en,
    output logic [DATA_W-1:0]        proc_wdata,
    output logic                     proc_last,
    // Status
    output logic                     busy,
    output logic                     len_err
);

    steer_state_e              state_q;
    steer_state_e              state_d;

    // Latched AW payload and route (1 = MERGE, 0 = REG_FLOW).
    logic [ADDR_W-1:0]         addr_q;
    logic [7:0]                len_q;
    logic [PAWUSER_WIDTH-1:0]  user_q;
    logic                      route_q;

    logic                      aw_hs;
    logic                      w_hs;

    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid & s_wready;

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // AW payload and route capture on the AW handshake; held for the burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            len_q   <= '0;
            user_q  <= '0;
            route_q <= 1'b0;
        end else if (aw_hs) begin
            addr_q  <= s_awaddr;
            len_q   <= s_awlen;
            user_q  <= s_awuser;
            route_q <= (routers_ps == RP_MERGE);
        end
    end

    // Next-state and handshake/steering outputs.
    // NOTE: every output and state_d gets a default first so no path through
    // the case leaves a variable unassigned (which would infer a latch).
    always_comb begin
        state_d    = state_q;
        s_awready  = 1'b0;
        m_awvalid  = 1'b0;
        s_wready   = 1'b0;
        m_wvalid   = 1'b0;
        m_wdata    = '0;
        m_wlast    = 1'b0;
        proc_wr_en = 1'b0;
        proc_wdata = '0;
        proc_last  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // rst_n gating keeps s_awready low while reset is asserted,
                // even if routers_ps already allows a new burst.
                s_awready = rst_n & accepts_aw(routers_ps);
                if (s_awvalid && s_awready) begin
                    state_d = (routers_ps == RP_MERGE) ? ST_DATA : ST_AW;
                end
            end

            ST_AW: begin
                m_awvalid = 1'b1;
                if (m_awready) begin
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                if (route_q) begin
                    // MERGE: proc port back-pressure via proc_full.
                    s_wready   = ~proc_full;
                    proc_wr_en = s_wvalid & ~proc_full;
                    proc_wdata = s_wdata;
                    proc_last  = s_wlast;
                end else begin
                    // REG_FLOW: zero-latency pass-through to master W.
                    m_wvalid = s_wvalid;
                    s_wready = m_wready;
                    m_wdata  = s_wdata;
                    m_wlast  = s_wlast;
                end
                // Leaving through ST_IDLE guarantees an idle cycle between
                // bursts, since s_awready is only raised in ST_IDLE.
                if (s_wvalid && s_wready && s_wlast) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign m_awaddr = addr_q;
    assign m_awlen  = len_q;
    assign m_awuser = user_q;
    assign busy     = (state_q != ST_IDLE);

`ifdef STEER_LEN_CHECK_EN
    logic [7:0] beat_cnt_q;
    logic       len_err_q;

    // Beat counter: cleared on each AW acceptance, advanced per accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
        end else if (aw_hs) begin
            beat_cnt_q <= '0;
        end else if (state_q == ST_DATA && w_hs) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
        end
    end

    // Sticky length flag: beat index len must be exactly the beat with s_wlast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_err_q <= 1'b0;
        end else if (state_q == ST_DATA && w_hs && (s_wlast != (beat_cnt_q == len_q))) begin
            len_err_q <= 1'b1;
        end
    end

    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_aw_w_steer.sv
// Self-checking bench for aw_w_steer. Directed scenarios plus randomized
// bursts; each burst's expected beat stream is generated up front and
// compared against what actually appears on the selected output port.
// Honors STEER_LEN_CHECK_EN the same way the design does.
module tb_aw_w_steer;
    import aw_w_steer_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [2:0]               routers_ps;
    logic                     s_awvalid;
    logic                     s_awready;
    logic [ADDR_W-1:0]        s_awaddr;
    logic [7:0]               s_awlen;
    logic [PAWUSER_WIDTH-1:0] s_awuser;
    logic                     s_wvalid;
    logic                     s_wready;
    logic [DATA_W-1:0]        s_wdata;
    logic                     s_wlast;
    logic                     m_awvalid;
    logic                     m_awready;
    logic [ADDR_W-1:0]        m_awaddr;
    logic [7:0]               m_awlen;
    logic [PAWUSER_WIDTH-1:0] m_awuser;
    logic                     m_wvalid;
    logic                     m_wready;
    logic [DATA_W-1:0]        m_wdata;
    logic                     m_wlast;
    logic                     proc_full;
    logic                     proc_wr_en;
    logic [DATA_W-1:0]        proc_wdata;
    logic                     proc_last;
    logic                     busy;
    logic                     len_err;

    int vectors     = 0;
    int miscompares = 0;
    bit len_err_exp = 1'b0;

    always #5 clk = ~clk;

    aw_w_steer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .routers_ps (routers_ps),
        .s_awvalid  (s_awvalid),
        .s_awready  (s_awready),
        .s_awaddr   (s_awaddr),
        .s_awlen    (s_awlen),
        .s_awuser   (s_awuser),
        .s_wvalid   (s_wvalid),
        .s_wready   (s_wready),
        .s_wdata    (s_wdata),
        .s_wlast    (s_wlast),
        .m_awvalid  (m_awvalid),
        .m_awready  (m_awready),
        .m_awaddr   (m_awaddr),
        .m_awlen    (m_awlen),
        .m_awuser   (m_awuser),
        .m_wvalid   (m_wvalid),
        .m_wready   (m_wready),
        .m_wdata    (m_wdata),
        .m_wlast    (m_wlast),
        .proc_full  (proc_full),
        .proc_wr_en (proc_wr_en),
        .proc_wdata (proc_wdata),
        .proc_last  (proc_last),
        .busy       (busy),
        .len_err    (len_err)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full burst. ps: route at acceptance; awlen: AW len field; nbeats:
    // beats actually sent (last one flagged); mode 0 = no stalls, 1 = random
    // stalls, 2 = proc_full for 3 cycles on beat index 1; sw = flip
    // routers_ps once beat index 1 is reached.
    task automatic do_burst(input logic [2:0] ps, input logic [7:0] awlen,
                            input int nbeats, input int mode, input bit sw);
        logic [ADDR_W-1:0]        addr;
        logic [PAWUSER_WIDTH-1:0] user;
        logic [DATA_W-1:0]        q[$];
        bit                       merge;
        bit                       exp_ready;
        int                       i;
        int                       got;
        int                       cyc;
        int                       stall;
        int                       full_cycles;

        merge = (ps == RP_MERGE);
        addr  = $urandom;
        user  = PAWUSER_WIDTH'($urandom);
        for (int k = 0; k < nbeats; k++) q.push_back({$urandom, $urandom});

        routers_ps = ps;
        s_awvalid  = 1'b1;
        s_awaddr   = addr;
        s_awlen    = awlen;
        s_awuser   = user;
        #1;
        check("aw_ready_idle", s_awready, 1);
        step();
        s_awvalid = 1'b0;
        s_awaddr  = '0;
        s_awlen   = '0;
        s_awuser  = '0;
        #1;
        check("busy_after_accept", busy, 1);

        if (!merge) begin
            stall = (mode == 1) ? int'($urandom_range(0, 3)) : 0;
            for (int c = 0; c <= stall; c++) begin
                m_awready = (c == stall);
                #1;
                check("m_awvalid_reg", m_awvalid, 1);
                check("m_awaddr", m_awaddr, addr);
                check("m_awlen", m_awlen, awlen);
                check("m_awuser", m_awuser, user);
                step();
            end
            m_awready = 1'b0;
        end
        check("m_awvalid_data", m_awvalid, 0);

        i = 0;
        got = 0;
        cyc = 0;
        full_cycles = 0;
        while (i < nbeats && cyc < 200) begin
            if (sw && i == 1) routers_ps = merge ? RP_MERGE : RP_REG_FLOW;
            if (sw && i == 1) routers_ps = merge ? RP_REG_FLOW : RP_MERGE;
            s_wvalid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_wdata  = q[i];
            s_wlast  = (i == nbeats - 1);
            s_awvalid = s_wlast;
            case (mode)
                1: begin
                    m_wready  = ($urandom_range(0, 3) != 0);
                    proc_full = ($urandom_range(0, 3) == 0);
                end
                2: begin
                    m_wready  = 1'b1;
                    proc_full = (i == 1 && full_cycles < 3);
                end
                default: begin
                    m_wready  = 1'b1;
                    proc_full = 1'b0;
                end
            endcase
            #1;
            exp_ready = merge ? !proc_full : m_wready;
            check("s_wready", s_wready, exp_ready);
            check("m_awvalid_quiet", m_awvalid, 0);
            if (s_awvalid) check("no_aw_during_data", s_awready, 0);
            if (merge) check("m_wvalid_merge", m_wvalid, 0);
            else       check("proc_wr_en_reg", proc_wr_en, 0);
            if ((m_wvalid && m_wready) || proc_wr_en) begin
                if (got < nbeats) begin
                    check("beat_data", merge ? proc_wdata : m_wdata, q[got]);
                    check("beat_last", merge ? proc_last : m_wlast, got == nbeats - 1);
                end else begin
                    check("extra_beat", 1, 0);
                end
                got++;
            end
            if (mode == 2 && proc_full) full_cycles++;
            if (s_wvalid && exp_ready) i++;
            step();
            cyc++;
        end
        if (cyc >= 200) check("burst_timeout", 0, 1);

        s_wvalid  = 1'b0;
        s_wlast   = 1'b0;
        s_awvalid = 1'b0;
        proc_full = 1'b0;
        m_wready  = 1'b0;
        #1;
        check("busy_after_last", busy, 0);
        check("beats_delivered", got, nbeats);
        if (mode == 2) check("full_stall_cycles", full_cycles, 3);
`ifdef STEER_LEN_CHECK_EN
        if (nbeats != int'(awlen) + 1) len_err_exp = 1'b1;
`endif
        check("len_err", len_err, len_err_exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        routers_ps = RP_REG_FLOW;
        s_awvalid  = 1'b1;
        s_awaddr   = '1;
        s_awlen    = 8'd5;
        s_awuser   = '1;
        s_wvalid   = 1'b1;
        s_wdata    = '1;
        s_wlast    = 1'b1;
        m_awready  = 1'b0;
        m_wready   = 1'b1;
        proc_full  = 1'b0;

        // Reset state with hostile inputs applied.
        step();
        step();
        check("rst_s_awready", s_awready, 0);
        check("rst_s_wready", s_wready, 0);
        check("rst_m_awvalid", m_awvalid, 0);
        check("rst_m_wvalid", m_wvalid, 0);
        check("rst_proc_wr_en", proc_wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_len_err", len_err, 0);
        check("rst_m_awaddr", m_awaddr, 0);
        check("rst_m_awlen", m_awlen, 0);
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_wlast   = 1'b0;
        m_wready  = 1'b0;
        routers_ps = RP_BLOCKED;
        rst_n = 1'b1;
        step();

        // BLOCKED then IDLE router states hold s_awready low.
        s_awvalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            routers_ps = (c < 5) ? RP_BLOCKED : RP_IDLE;
            #1;
            check("blocked_awready", s_awready, 0);
            check("blocked_busy", busy, 0);
            step();
        end
        // Switch to REG_FLOW: accepted in that same cycle; len=3, 4 beats.
        do_burst(RP_REG_FLOW, 8'd3, 4, 0, 1'b0);

        // MERGE, len=1, proc_full held for 3 cycles on beat 2.
        do_burst(RP_MERGE, 8'd1, 2, 2, 1'b0);

        // REG burst with routers_ps flipping to MERGE mid-burst.
        do_burst(RP_REG_FLOW, 8'd4, 5, 0, 1'b1);
        // MERGE burst with routers_ps flipping to REG_FLOW mid-burst.
        do_burst(RP_MERGE, 8'd3, 4, 1, 1'b1);

        // Randomized well-formed bursts.
        for (int b = 0; b < 25; b++) begin
            int n;
            n = int'($urandom_range(1, 8));
            do_burst(($urandom_range(0, 1) != 0) ? RP_MERGE : RP_REG_FLOW,
                     8'(n - 1), n, 1, $urandom_range(0, 1) != 0);
        end

        // Short burst: len=3 but s_wlast on beat 2.
        do_burst(RP_REG_FLOW, 8'd3, 2, 0, 1'b0);
        // Flag (if enabled) must persist across a later clean burst.
        do_burst(RP_MERGE, 8'd2, 3, 0, 1'b0);

        // Asynchronous reset in the middle of a REG data phase.
        routers_ps = RP_REG_FLOW;
        s_awvalid  = 1'b1;
        s_awlen    = 8'd7;
        step();
        s_awvalid  = 1'b0;
        m_awready  = 1'b1;
        step();
        m_awready  = 1'b0;
        s_wvalid   = 1'b1;
        s_wdata    = 64'h1234_5678_9abc_def0;
        m_wready   = 1'b1;
        #1;
        check("pre_rst_m_wvalid", m_wvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_m_wvalid", m_wvalid, 0);
        check("async_rst_s_wready", s_wready, 0);
        check("async_rst_s_awready", s_awready, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_m_awvalid", m_awvalid, 0);
        check("async_rst_len_err", len_err, 0);
        len_err_exp = 1'b0;
        routers_ps = RP_BLOCKED;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("post_rst_m_wvalid", m_wvalid, 0);
            check("post_rst_proc_wr_en", proc_wr_en, 0);
            check("post_rst_s_wready", s_wready, 0);
            check("post_rst_busy", busy, 0);
        end
        s_wvalid = 1'b0;
        m_wready = 1'b0;
        step();

        // Normal operation resumes after reset.
        do_burst(RP_REG_FLOW, 8'd2, 3, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aw_w_steer.md
AW_W_STEER -- requirements
Module: aw_w_steer

Interface
REQ-001 Parameter ADDR_W, default 32, address width of the AW channel.
REQ-002 Parameter DATA_W, default 64, width of W data and of the proc write port.
REQ-003 clk input 1: clock; all state updates on the rising edge.
REQ-004 rst_n input 1: reset, asynchronous, active-low.
REQ-005 routers_ps input 3: router state; 000 REG_FLOW, 001 BLOCKED, 010 MERGE, 111 IDLE.
REQ-006 s_awvalid/s_awready input/output 1 each: slave AW handshake.
REQ-007 s_awaddr input ADDR_W, s_awlen input 8, s_awuser input PAWUSER_WIDTH: slave AW payload.
REQ-008 s_wvalid/s_wready input/output 1 each, s_wdata input DATA_W, s_wlast input 1: slave W channel.
REQ-009 m_awvalid output 1, m_awready input 1, m_awaddr/m_awlen/m_awuser outputs ADDR_W/8/PAWUSER_WIDTH: master AW.
REQ-010 m_wvalid output 1, m_wready input 1, m_wdata output DATA_W, m_wlast output 1: master W.
REQ-011 proc_full input 1, proc_wr_en output 1, proc_wdata output DATA_W, proc_last output 1: proc memory write port.
REQ-012 busy output 1: a burst is accepted and not yet finished.
REQ-013 len_err output 1: sticky burst-length mismatch flag (see REQ-030).

Function
REQ-014 The internal FSM SHALL have the states ST_IDLE, ST_AW, ST_DATA.
REQ-015 In ST_IDLE, s_awready SHALL be 1 only when routers_ps is REG_FLOW or MERGE; BLOCKED and IDLE hold s_awready at 0.
REQ-016 On an AW handshake, the block SHALL latch addr, len, user and route_q (0 = REG_FLOW, 1 = MERGE) from routers_ps in that cycle.
REQ-017 route_q SHALL stay fixed until the burst ends; a routers_ps change mid-burst SHALL NOT split or redirect it.
REQ-018 REG route: the next state SHALL be ST_AW, and m_awvalid SHALL be 1 from the cycle after acceptance, carrying the latched payload.
REQ-019 In ST_AW, m_awvalid and the payload SHALL hold stable until m_awready; then the next state SHALL be ST_DATA.
REQ-020 MERGE route: the next state SHALL be ST_DATA directly; m_awvalid SHALL stay 0.
REQ-021 In ST_DATA, REG route, m_wvalid SHALL be s_wvalid, s_wready SHALL be m_wready, and m_wdata/m_wlast SHALL be s_wdata/s_wlast, with zero latency.
REQ-022 In ST_DATA, MERGE route, s_wready SHALL be ~proc_full, proc_wr_en SHALL be s_wvalid & ~proc_full, and proc_wdata/proc_last SHALL be s_wdata/s_wlast.
REQ-023 A W beat SHALL transfer only on valid & ready; the accepted beat with s_wlast=1 SHALL return the FSM to ST_IDLE in the next cycle.
REQ-024 Outside ST_DATA: s_wready, m_wvalid and proc_wr_en SHALL be 0.
REQ-025 A new AW SHALL NOT be accepted in the cycle the last beat completes (one idle cycle minimum between bursts).
REQ-026 When proc_full rises mid-burst, the block SHALL stall with no beat lost or duplicated, and SHALL resume when proc_full falls.
REQ-027 busy SHALL be 1 in ST_AW and ST_DATA.

Reset
REQ-028 On rst_n low, the FSM SHALL go to ST_IDLE; all valid, ready, proc_wr_en, busy and len_err outputs SHALL be 0; latched payload and counter SHALL be 0.
REQ-029 A reset in mid-burst SHALL abandon the burst; no beat is forwarded in the cycles after reset release.

Configuration
REQ-030 With STEER_LEN_CHECK_EN defined, an 8-bit beat counter SHALL count accepted beats; len_err SHALL set when s_wlast arrives at count != len, or when count reaches len with no s_wlast. len_err SHALL clear only on reset.
REQ-031 Without STEER_LEN_CHECK_EN, there SHALL be no counter and len_err SHALL be tied to 0; termination SHALL use s_wlast only.

Structure
REQ-032 The routers_ps state encodings, PAWUSER_WIDTH, and the steer FSM state enum SHALL reside in pkg.
REQ-033 The block SHALL have no sub-module; the AW payload register is inline.

Verification
REQ-034 REG_FLOW, AW len=3, m_awready=1 -> m_awvalid one cycle after acceptance, 4 beats on m_w*, m_wlast on beat 4, busy drops the next cycle.
REQ-035 MERGE, len=1, proc_full=1 during beat 2 for 3 cycles -> s_wready=0 for exactly those cycles, 2 proc_wr_en pulses total, m_awvalid never 1.
REQ-036 routers_ps=BLOCKED, s_awvalid=1 for 10 cycles -> s_awready=0 throughout; switching to REG_FLOW -> accepted in that cycle.
REQ-037 REG burst in progress, routers_ps switches to MERGE -> remaining beats still on m_w*, proc_wr_en=0.
REQ-038 STEER_LEN_CHECK_EN, len=3, s_wlast on beat 2 -> len_err=1 from the next cycle until reset.
REQ-039 rst_n pulsed low during ST_DATA -> all outputs 0 asynchronously, ST_IDLE after release.
